// File: rtl/spoc_bdo_postproc.sv
// -----------------------------------------------------------------------------
// spoc_bdo_postproc
//
// Output-side post-processor for the SpoC-64 LWC core. Frames each operation's
// result stream onto the external LWC "do" port:
//   message header -> masked message words -> tag header + tag words (encrypt)
//   or decrypt verdict -> status word (do_last = 1).
//
// Optional feature macro: SPOC_POSTPROC_LEN_CHECK_EN
//   defined   : err is a sticky flag raised on end_of_block / byte-mask
//               inconsistencies in the DATA and TAG streams.
//   undefined : err is tied to 0 and no check logic is built.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   op_valid/op_ready         operation descriptor handshake
//   op_decrypt, op_len        descriptor: direction and message length (bytes)
//   bdo/bdo_valid/bdo_ready   core output words (big-endian)
//   bdo_valid_bytes           per-byte valid mask (bit 3 = byte 0)
//   end_of_block              last word of message or tag (length check only)
//   msg_auth_valid/_ready     decrypt verdict handshake, msg_auth = tag match
//   do_data/do_valid/do_ready external output stream, do_last on status word
//   err                       sticky length-check error
// -----------------------------------------------------------------------------
module spoc_bdo_postproc #(
  parameter int W         = 32,
  parameter int TAG_WORDS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic         op_decrypt,
  input  logic [15:0]  op_len,
  input  logic [W-1:0] bdo,
  input  logic         bdo_valid,
  output logic         bdo_ready,
  input  logic [3:0]   bdo_valid_bytes,
  input  logic         end_of_block,
  input  logic         msg_auth_valid,
  output logic         msg_auth_ready,
  input  logic         msg_auth,
  output logic [W-1:0] do_data,
  output logic         do_valid,
  input  logic         do_ready,
  output logic         do_last,
  output logic         err
);

  localparam int             TCW        = (TAG_WORDS > 1) ? $clog2(TAG_WORDS) : 1;
  localparam logic [TCW-1:0] TCNT_LAST  = TCW'(TAG_WORDS - 1);
  localparam logic [W-1:0]   TAG_HDR    = 32'h8700_0010;
  localparam logic [W-1:0]   STATUS_OK  = 32'hE000_0000;
  localparam logic [W-1:0]   STATUS_BAD = 32'hF000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_MSG,
    S_DATA,
    S_HDR_TAG,
    S_TAG,
    S_WAIT_AUTH,
    S_STATUS
  } state_t;

  state_t         state_q, state_d;
  logic           dec_q, dec_d;
  logic           pass_q, pass_d;
  logic [15:0]    rem_q, rem_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;

  logic [W-1:0]   do_data_q;
  logic           do_last_q;
  logic           do_valid_q;

  logic           ld_ok;
  logic           op_hs, bdo_hs, auth_hs;
  logic           data_last, tag_last;
  logic [W-1:0]   masked_bdo;
  logic           load_en;
  logic [W-1:0]   load_data;
  logic           load_last;

  // The output register may take a new word when empty or being drained now.
  assign ld_ok     = !do_valid_q || do_ready;
  assign op_hs     = op_valid && op_ready;
  assign bdo_hs    = bdo_valid && bdo_ready;
  assign auth_hs   = msg_auth_valid && msg_auth_ready;
  assign data_last = (rem_q <= 16'd4);
  assign tag_last  = (tcnt_q == TCNT_LAST);

  // Byte lane k ([8k+7:8k]) is qualified by bdo_valid_bytes[k].
  always_comb begin
    masked_bdo = '0;
    for (int k = 0; k < 4; k++) begin
      masked_bdo[8*k +: 8] = bdo_valid_bytes[k] ? bdo[8*k +: 8] : 8'h00;
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      dec_q      <= 1'b0;
      pass_q     <= 1'b0;
      rem_q      <= '0;
      tcnt_q     <= '0;
      do_data_q  <= '0;
      do_last_q  <= 1'b0;
      do_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      pass_q  <= pass_d;
      rem_q   <= rem_d;
      tcnt_q  <= tcnt_d;
      if (load_en) begin
        do_data_q  <= load_data;
        do_last_q  <= load_last;
        do_valid_q <= 1'b1;
      end else if (do_ready) begin
        // Drained with nothing new to load; data is held, only valid drops.
        do_valid_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in a combinational block gets a default first,
  // so no path through the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    pass_d  = pass_q;
    rem_d   = rem_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (op_hs) begin
          dec_d = op_decrypt;
          rem_d = op_len;
          if (op_len == 16'd0) begin
            state_d = op_decrypt ? S_WAIT_AUTH : S_HDR_TAG;
          end else begin
            state_d = S_HDR_MSG;
          end
        end
      end
      S_HDR_MSG: begin
        if (ld_ok) state_d = S_DATA;
      end
      S_DATA: begin
        if (bdo_hs) begin
          // Saturating decrement: the last word may carry fewer than 4 bytes.
          rem_d = data_last ? 16'd0 : (rem_q - 16'd4);
          if (data_last) state_d = dec_q ? S_WAIT_AUTH : S_HDR_TAG;
        end
      end
      S_HDR_TAG: begin
        if (ld_ok) begin
          tcnt_d  = '0;
          state_d = S_TAG;
        end
      end
      S_TAG: begin
        if (bdo_hs) begin
          tcnt_d = tcnt_q + TCW'(1);
          if (tag_last) begin
            pass_d  = 1'b1;
            state_d = S_STATUS;
          end
        end
      end
      S_WAIT_AUTH: begin
        if (auth_hs) begin
          pass_d  = msg_auth;
          state_d = S_STATUS;
        end
      end
      S_STATUS: begin
        if (ld_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / handshake logic
  // ---------------------------------------------------------------------------
  always_comb begin
    op_ready       = 1'b0;
    bdo_ready      = 1'b0;
    msg_auth_ready = 1'b0;
    load_en        = 1'b0;
    load_data      = '0;
    load_last      = 1'b0;
    unique case (state_q)
      S_IDLE: op_ready = 1'b1;
      S_HDR_MSG: begin
        load_en   = ld_ok;
        // {type, 0, eoi, eot, last, 8'h00, len}; rem still equals op_len here.
        load_data = {(dec_q ? 4'h4 : 4'h5), 1'b0, dec_q, 2'b11, 8'h00, rem_q};
      end
      S_DATA: begin
        bdo_ready = ld_ok;
        load_en   = bdo_valid && ld_ok;
        load_data = masked_bdo;
      end
      S_HDR_TAG: begin
        load_en   = ld_ok;
        load_data = TAG_HDR;
      end
      S_TAG: begin
        bdo_ready = ld_ok;
        load_en   = bdo_valid && ld_ok;
        load_data = bdo;
      end
      S_WAIT_AUTH: msg_auth_ready = 1'b1;
      S_STATUS: begin
        load_en   = ld_ok;
        load_data = pass_q ? STATUS_OK : STATUS_BAD;
        load_last = 1'b1;
      end
      default: ;
    endcase
  end

  assign do_data  = do_data_q;
  assign do_last  = do_last_q;
  assign do_valid = do_valid_q;

  // ---------------------------------------------------------------------------
  // Optional length consistency check
  // ---------------------------------------------------------------------------
`ifdef SPOC_POSTPROC_LEN_CHECK_EN
  logic       err_q;
  logic [3:0] exp_mask;
  logic       len_err;

  // Byte mask expected on the last message word for rem = 1..4.
  always_comb begin
    unique case (rem_q[2:0])
      3'd1:    exp_mask = 4'b1000;
      3'd2:    exp_mask = 4'b1100;
      3'd3:    exp_mask = 4'b1110;
      default: exp_mask = 4'b1111;
    endcase
  end

  always_comb begin
    len_err = 1'b0;
    if (state_q == S_DATA && bdo_hs) begin
      if (end_of_block != data_last)                 len_err = 1'b1;
      if (data_last && bdo_valid_bytes != exp_mask)  len_err = 1'b1;
    end
    if (state_q == S_TAG && bdo_hs && tag_last && !end_of_block) len_err = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         err_q <= 1'b0;
    else if (len_err) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  logic unused_end_of_block;
  assign unused_end_of_block = end_of_block;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_spoc_bdo_postproc.sv
// -----------------------------------------------------------------------------
// tb_spoc_bdo_postproc
//
// Scoreboard bench for spoc_bdo_postproc. Drivers push the expected do-stream
// words ({do_last, do_data}) as stimulus is applied; a monitor pops and compares
// on every do handshake. Covers encrypt/decrypt framing, zero-length messages,
// byte masking, do_ready backpressure, the optional length check and reset.
// -----------------------------------------------------------------------------
module tb_spoc_bdo_postproc;

`ifdef SPOC_POSTPROC_LEN_CHECK_EN
  localparam bit LEN_CHECK = 1'b1;
`else
  localparam bit LEN_CHECK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic        op_decrypt;
  logic [15:0] op_len;
  logic [31:0] bdo;
  logic        bdo_valid;
  logic        bdo_ready;
  logic [3:0]  bdo_valid_bytes;
  logic        end_of_block;
  logic        msg_auth_valid;
  logic        msg_auth_ready;
  logic        msg_auth;
  logic [31:0] do_data;
  logic        do_valid;
  logic        do_ready;
  logic        do_last;
  logic        err;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp_w;
  bit          toggle_rdy = 1'b0;

  spoc_bdo_postproc #(.W(32), .TAG_WORDS(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .op_valid       (op_valid),
    .op_ready       (op_ready),
    .op_decrypt     (op_decrypt),
    .op_len         (op_len),
    .bdo            (bdo),
    .bdo_valid      (bdo_valid),
    .bdo_ready      (bdo_ready),
    .bdo_valid_bytes(bdo_valid_bytes),
    .end_of_block   (end_of_block),
    .msg_auth_valid (msg_auth_valid),
    .msg_auth_ready (msg_auth_ready),
    .msg_auth       (msg_auth),
    .do_data        (do_data),
    .do_valid       (do_valid),
    .do_ready       (do_ready),
    .do_last        (do_last),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Sink side: do_ready either held high or toggled every cycle.
  initial begin
    do_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      do_ready = toggle_rdy ? ~do_ready : 1'b1;
    end
  end

  // Monitor: inputs only change at posedge+1, so a handshake seen at the
  // negedge completes on the following posedge.
  always @(negedge clk) begin
    if (rst && do_valid && do_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_word", {31'd0, do_last, do_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_w = exp_q.pop_front();
        check("do_word", {31'd0, do_last, do_data}, {31'd0, exp_w});
      end
    end
    if (rst && do_valid && !do_ready) check("bp_bdo_ready", {63'd0, bdo_ready}, 64'd0);
  end

  // Waits (bounded) for a ready signal, then steps past the handshake edge.
  // sel: 0 = op_ready, 1 = bdo_ready, 2 = msg_auth_ready.
  task automatic wait_hs(input int sel);
    int   t;
    logic r;
    t = 0;
    @(negedge clk);
    r = (sel == 0) ? op_ready : (sel == 1) ? bdo_ready : msg_auth_ready;
    while (!r && t < 200) begin
      @(negedge clk);
      t++;
      r = (sel == 0) ? op_ready : (sel == 1) ? bdo_ready : msg_auth_ready;
    end
    if (!r) check("hs_timeout", {63'd0, r}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input bit dec, input logic [15:0] len);
    if (len != 16'd0)
      exp_q.push_back({1'b0, (dec ? 8'h47 : 8'h53), 8'h00, len});
    else if (!dec)
      exp_q.push_back({1'b0, 32'h8700_0010});
    op_valid   = 1'b1;
    op_decrypt = dec;
    op_len     = len;
    wait_hs(0);
    op_valid   = 1'b0;
  endtask

  task automatic send_bdo(input logic [31:0] d, input logic [3:0] vb, input bit eob,
                          input logic [31:0] exp_d);
    exp_q.push_back({1'b0, exp_d});
    bdo             = d;
    bdo_valid_bytes = vb;
    end_of_block    = eob;
    bdo_valid       = 1'b1;
    wait_hs(1);
    bdo_valid       = 1'b0;
    end_of_block    = 1'b0;
  endtask

  // Tag header (for non-empty encrypts) is pushed here; empty ones push it in start_op.
  task automatic send_tag(input bit push_hdr);
    logic [31:0] t;
    if (push_hdr) exp_q.push_back({1'b0, 32'h8700_0010});
    for (int i = 0; i < 4; i++) begin
      t = $urandom;
      send_bdo(t, 4'hF, (i == 3), t);
    end
    exp_q.push_back({1'b1, 32'hE000_0000});
  endtask

  task automatic send_auth(input bit ok);
    exp_q.push_back({1'b1, (ok ? 32'hE000_0000 : 32'hF000_0000)});
    msg_auth       = ok;
    msg_auth_valid = 1'b1;
    wait_hs(2);
    msg_auth_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w;
    rst = 1'b0;
    op_valid = 1'b0; op_decrypt = 1'b0; op_len = '0;
    bdo = '0; bdo_valid = 1'b0; bdo_valid_bytes = '0; end_of_block = 1'b0;
    msg_auth_valid = 1'b0; msg_auth = 1'b0;

    // Reset state
    #12;
    check("rst_do_valid",  {63'd0, do_valid}, 64'd0);
    check("rst_do_data",   {32'd0, do_data}, 64'd0);
    check("rst_do_last",   {63'd0, do_last}, 64'd0);
    check("rst_op_ready",  {63'd0, op_ready}, 64'd1);
    check("rst_bdo_ready", {63'd0, bdo_ready}, 64'd0);
    check("rst_auth_rdy",  {63'd0, msg_auth_ready}, 64'd0);
    check("rst_err",       {63'd0, err}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Encrypt, 5 bytes: partial last word masked to byte 0
    start_op(1'b0, 16'd5);
    send_bdo(32'h1122_3344, 4'b1111, 1'b0, 32'h1122_3344);
    send_bdo(32'h5566_7788, 4'b1000, 1'b1, 32'h5500_0000);
    send_tag(1'b1);
    drain();
    check("err_enc5", {63'd0, err}, 64'd0);

    // Decrypt, 8 bytes, verdict fail then pass (back to back)
    start_op(1'b1, 16'd8);
    send_bdo(32'hA5A5_0001, 4'b1111, 1'b0, 32'hA5A5_0001);
    send_bdo(32'h5A5A_0002, 4'b1111, 1'b1, 32'h5A5A_0002);
    send_auth(1'b0);
    start_op(1'b1, 16'd8);
    send_bdo(32'h0102_0304, 4'b1111, 1'b0, 32'h0102_0304);
    send_bdo(32'h0506_0708, 4'b1111, 1'b1, 32'h0506_0708);
    send_auth(1'b1);
    drain();

    // Encrypt, empty message: tag header one cycle after the op handshake
    start_op(1'b0, 16'd0);
    @(posedge clk); #1;
    check("lat_hdr_valid", {63'd0, do_valid}, 64'd1);
    check("lat_hdr_data",  {32'd0, do_data}, 64'h8700_0010);
    send_tag(1'b0);
    drain();

    // Decrypt, 3 bytes: masked last word
    start_op(1'b1, 16'd3);
    send_bdo(32'hCAFE_BABE, 4'b1110, 1'b1, 32'hCAFE_BA00);
    send_auth(1'b1);
    drain();

    // Backpressure: do_ready toggling through a 16-byte encrypt
    toggle_rdy = 1'b1;
    start_op(1'b0, 16'd16);
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      send_bdo(w, 4'b1111, (i == 3), w);
    end
    send_tag(1'b1);
    drain();
    toggle_rdy = 1'b0;
    @(posedge clk); #1;
    check("err_toggle", {63'd0, err}, 64'd0);

    // Length mismatch: 6 bytes but last word marks only byte 0 valid
    start_op(1'b0, 16'd6);
    send_bdo(32'hAABB_CCDD, 4'b1111, 1'b0, 32'hAABB_CCDD);
    send_bdo(32'hEEFF_0011, 4'b1000, 1'b1, 32'hEE00_0000);
    send_tag(1'b1);
    drain();
    check("err_set", {63'd0, err}, {63'd0, LEN_CHECK});
    start_op(1'b1, 16'd4);
    send_bdo(32'h1357_9BDF, 4'b1111, 1'b1, 32'h1357_9BDF);
    send_auth(1'b0);
    drain();
    check("err_sticky", {63'd0, err}, {63'd0, LEN_CHECK});

    // Asynchronous reset mid-DATA, then a fresh op
    start_op(1'b0, 16'd12);
    send_bdo(32'h2468_ACE0, 4'b1111, 1'b0, 32'h2468_ACE0);
    #3;
    rst = 1'b0;
    #1;
    check("mid_rst_do_valid",  {63'd0, do_valid}, 64'd0);
    check("mid_rst_op_ready",  {63'd0, op_ready}, 64'd1);
    check("mid_rst_bdo_ready", {63'd0, bdo_ready}, 64'd0);
    check("mid_rst_err",       {63'd0, err}, 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    start_op(1'b0, 16'd7);
    send_bdo(32'h0F1E_2D3C, 4'b1111, 1'b0, 32'h0F1E_2D3C);
    send_bdo(32'h4B5A_6978, 4'b1110, 1'b1, 32'h4B5A_6900);
    send_tag(1'b1);
    drain();
    check("err_after_rst", {63'd0, err}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
